mem_loader: RTL and testbench

- Upstream feeder for the 16-bit program/data memory (WIDTH=16, 2048 words).
- Takes the byte stream from the UART receiver and parses a framed load command.
- Packs byte pairs into words and writes them to consecutive memory addresses starting at 0.
- Reports busy/done/error status to the debug unit.

---
 rtl/mem_loader_pkg.sv | 21 ++
 rtl/mem_loader.sv | 176 +++++++++++++++++
 tb/tb_mem_loader.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_loader_pkg.sv
// Shared constants and FSM encoding for the memory loader.
// Memory and debug unit import the same definitions.
package mem_loader_pkg;

   localparam int WIDTH  = 16;
   localparam int DEPTH  = 2048;
   localparam int ADDR_W = 11;

   localparam logic [7:0] START_CMD = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      BYTE_HI,
      BYTE_LO,
      CHECK,
      DONE
   } state_e;

endpackage

// File: rtl/mem_loader.sv
// Parses framed UART load commands and writes 16-bit words from address 0.
// Define MEM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module mem_loader
   import mem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_done,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WIDTH-1:0]  mem_wdata,
   output logic              busy,
   output logic              load_done,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);

   state_e              state_q, state_d;
   logic [7:0]          len_lo_q, len_lo_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic [7:0]          hi_q, hi_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W:0]     wc_q, wc_d;
   logic                err_q, err_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [WIDTH-1:0]    wdata_q, wdata_d;
   logic [15:0]         n;
`ifdef MEM_LOADER_CHECKSUM_EN
   logic [7:0]          csum_q, csum_d;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         len_lo_q <= '0;
         len_q    <= '0;
         hi_q     <= '0;
         ptr_q    <= '0;
         wc_q     <= '0;
         err_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
         csum_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         len_lo_q <= len_lo_d;
         len_q    <= len_d;
         hi_q     <= hi_d;
         ptr_q    <= ptr_d;
         wc_q     <= wc_d;
         err_q    <= err_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
`ifdef MEM_LOADER_CHECKSUM_EN
         csum_q   <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      len_lo_d = len_lo_q;
      len_d    = len_q;
      hi_d     = hi_q;
      ptr_d    = ptr_q;
      wc_d     = wc_q;
      err_d    = err_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      n        = {rx_data, len_lo_q};
`ifdef MEM_LOADER_CHECKSUM_EN
      csum_d   = csum_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (rx_done && rx_data == START_CMD) begin
               state_d = LEN_LO;
               err_d   = 1'b0;
               wc_d    = '0;
`ifdef MEM_LOADER_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         end
         LEN_LO: begin
            if (rx_done) begin
               len_lo_d = rx_data;
               state_d  = LEN_HI;
            end
         end
         LEN_HI: begin
            if (rx_done) begin
               if (n == 16'd0) begin
                  len_d = '0;
`ifdef MEM_LOADER_CHECKSUM_EN
                  state_d = CHECK;
`else
                  state_d = DONE;
`endif
               end else if (n > 16'(DEPTH)) begin
                  state_d = IDLE;
                  err_d   = 1'b1;
               end else begin
                  len_d   = n[ADDR_W:0];
                  ptr_d   = '0;
                  state_d = BYTE_HI;
               end
            end
         end
         BYTE_HI: begin
            if (rx_done) begin
               hi_d    = rx_data;
               state_d = BYTE_LO;
`ifdef MEM_LOADER_CHECKSUM_EN
               csum_d  = csum_q ^ rx_data;
`endif
            end
         end
         BYTE_LO: begin
            if (rx_done) begin
               we_d    = 1'b1;
               addr_d  = ptr_q;
               wdata_d = {hi_q, rx_data};
               ptr_d   = ptr_q + ADDR_W'(1);
               wc_d    = wc_q + (ADDR_W+1)'(1);
`ifdef MEM_LOADER_CHECKSUM_EN
               csum_d  = csum_q ^ rx_data;
`endif
               if (wc_d < len_q) begin
                  state_d = BYTE_HI;
               end else begin
`ifdef MEM_LOADER_CHECKSUM_EN
                  state_d = CHECK;
`else
                  state_d = DONE;
`endif
               end
            end
         end
`ifdef MEM_LOADER_CHECKSUM_EN
         CHECK: begin
            if (rx_done) begin
               if (rx_data == csum_q) begin
                  state_d = DONE;
               end else begin
                  state_d = IDLE;
                  err_d   = 1'b1;
               end
            end
         end
`endif
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign busy       = (state_q != IDLE) && (state_q != DONE);
   assign load_done  = (state_q == DONE);
   assign error      = err_q;
   assign word_count = wc_q;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: frames, errors, back-to-back and reset.
// Build with MEM_LOADER_CHECKSUM_EN to exercise the checksum byte.
module tb_mem_loader;
   import mem_loader_pkg::*;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [7:0]        rx_data = '0;
   logic              rx_done = 1'b0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [WIDTH-1:0]  mem_wdata;
   logic              busy;
   logic              load_done;
   logic              error;
   logic [ADDR_W:0]   word_count;

   mem_loader dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .load_done(load_done), .error(error),
      .word_count(word_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [WIDTH-1:0]  d;
      int                c;
   } exp_t;

   exp_t sb[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int we_cnt = 0;
   int ld_cnt = 0;

   always @(posedge clk) cyc++;

   // Expected writes carry the cycle they must appear in.
   always @(negedge clk) begin
      exp_t e;
      if (load_done === 1'b1) ld_cnt++;
      if (mem_we === 1'b1) begin
         we_cnt++;
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write got addr=%0h data=%0h want none",
                     mem_addr, mem_wdata);
         end else begin
            e = sb.pop_front();
            if (mem_addr !== e.a || mem_wdata !== e.d || cyc !== e.c) begin
               bad++;
               $display("FAIL write got addr=%0h data=%0h cyc=%0d want addr=%0h data=%0h cyc=%0d",
                        mem_addr, mem_wdata, cyc, e.a, e.d, e.c);
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rx_done = 1'b0;
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_done = 1'b1;
   endtask

   task automatic send_lo(input logic [7:0] b, input logic [ADDR_W-1:0] a,
                          input logic [WIDTH-1:0] d);
      exp_t e;
      @(negedge clk);
      e.a = a;
      e.d = d;
      e.c = cyc + 1;
      sb.push_back(e);
      rx_data = b;
      rx_done = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d[$], input bit b2b);
      int n;
      logic [7:0] x;
      n = d.size() / 2;
      x = 8'h00;
      send(START_CMD);
      if (!b2b) idle(1);
      send(n[7:0]);
      if (!b2b) idle(1);
      send(n[15:8]);
      if (!b2b) idle(1);
      for (int i = 0; i < n; i++) begin
         x = x ^ d[2*i] ^ d[2*i+1];
         send(d[2*i]);
         if (!b2b) idle(1);
         send_lo(d[2*i+1], i[ADDR_W-1:0], {d[2*i], d[2*i+1]});
         if (!b2b) idle(1);
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      send(x);
`endif
      idle(1);
   endtask

   task automatic settle();
      int k;
      k = 0;
      while (sb.size() != 0 && k < 20) begin
         idle(1);
         k++;
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain got pending=%0d want 0", sb.size());
         sb.delete();
      end
      idle(3);
   endtask

   task automatic check_end(input string nm, input int dwe, input int dld,
                            input int wc, input logic err,
                            input int we0, input int ld0);
      total++;
      if (we_cnt - we0 !== dwe || ld_cnt - ld0 !== dld ||
          word_count !== wc[ADDR_W:0] || busy !== 1'b0 || error !== err) begin
         bad++;
         $display("FAIL %s got we=%0d ld=%0d wc=%0d busy=%b err=%b want we=%0d ld=%0d wc=%0d busy=0 err=%b",
                  nm, we_cnt - we0, ld_cnt - ld0, word_count, busy, error,
                  dwe, dld, wc, err);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle(3);
      total++;
      if ({mem_we, mem_addr, mem_wdata, busy, load_done, error, word_count}
          !== '0) begin
         bad++;
         $display("FAIL reset got we=%b addr=%0h data=%0h busy=%b ld=%b err=%b wc=%0d want all 0",
                  mem_we, mem_addr, mem_wdata, busy, load_done, error, word_count);
      end
      reset = 1'b1;
      idle(2);
   endtask

   task automatic test_basic();
      int we0, ld0;
      logic [7:0] q[$];
      we0 = we_cnt;
      ld0 = ld_cnt;
      q = {8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
      send_frame(q, 1'b0);
      settle();
      check_end("basic", 3, 1, 3, 1'b0, we0, ld0);
   endtask

   task automatic test_len_err();
      int we0, ld0;
      logic [7:0] q[$];
      we0 = we_cnt;
      ld0 = ld_cnt;
      send(START_CMD); idle(1);
      send(8'h01); idle(1);
      send(8'h08); idle(3);
      check_end("len_2049", 0, 0, 0, 1'b1, we0, ld0);
      q = {};
      send_frame(q, 1'b0);
      settle();
      check_end("len_zero", 0, 1, 0, 1'b0, we0, ld0);
   endtask

   task automatic test_ignore();
      int we0, ld0;
      logic [7:0] q[$];
      we0 = we_cnt;
      ld0 = ld_cnt;
      send(8'h11); idle(1);
      send(8'h22); idle(2);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL ignore_busy got %b want 0", busy);
      end
      q = {8'hAA, 8'hBB};
      send_frame(q, 1'b0);
      settle();
      check_end("ignore", 1, 1, 1, 1'b0, we0, ld0);
   endtask

   task automatic test_back_to_back();
      int we0, ld0;
      logic [7:0] q[$];
      we0 = we_cnt;
      ld0 = ld_cnt;
      q = {START_CMD, START_CMD, 8'h01, 8'h02};
      send_frame(q, 1'b1);
      settle();
      check_end("b2b", 2, 1, 2, 1'b0, we0, ld0);
   endtask

   task automatic test_full();
      int we0, ld0;
      logic [7:0] q[$];
      we0 = we_cnt;
      ld0 = ld_cnt;
      q = {};
      for (int i = 0; i < DEPTH; i++) begin
         q.push_back(8'(i >> 3) ^ 8'h5C);
         q.push_back(8'(i * 7));
      end
      send_frame(q, 1'b1);
      settle();
      check_end("full_depth", DEPTH, 1, DEPTH, 1'b0, we0, ld0);
   endtask

   task automatic test_reset_mid();
      int we0, ld0;
      logic [7:0] q[$];
      send(START_CMD); idle(1);
      send(8'h04); idle(1);
      send(8'h00); idle(1);
      send(8'h12); idle(1);
      send_lo(8'h34, '0, 16'h1234); idle(1);
      settle();
      total++;
      if (busy !== 1'b1 || word_count !== 12'd1) begin
         bad++;
         $display("FAIL mid_busy got busy=%b wc=%0d want busy=1 wc=1",
                  busy, word_count);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      total++;
      if ({mem_we, mem_addr, mem_wdata, busy, load_done, error, word_count}
          !== '0) begin
         bad++;
         $display("FAIL mid_reset got we=%b addr=%0h data=%0h busy=%b ld=%b err=%b wc=%0d want all 0",
                  mem_we, mem_addr, mem_wdata, busy, load_done, error, word_count);
      end
      reset = 1'b1;
      idle(1);
      we0 = we_cnt;
      ld0 = ld_cnt;
      q = {8'hCD, 8'hEF};
      send_frame(q, 1'b0);
      settle();
      check_end("after_reset", 1, 1, 1, 1'b0, we0, ld0);
   endtask

`ifdef MEM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      int we0, ld0;
      we0 = we_cnt;
      ld0 = ld_cnt;
      send(START_CMD); idle(1);
      send(8'h01); idle(1);
      send(8'h00); idle(1);
      send(8'h12); idle(1);
      send_lo(8'h34, '0, 16'h1234); idle(1);
      send(8'h26); idle(1);
      settle();
      check_end("csum_ok", 1, 1, 1, 1'b0, we0, ld0);
      we0 = we_cnt;
      ld0 = ld_cnt;
      send(START_CMD); idle(1);
      send(8'h01); idle(1);
      send(8'h00); idle(1);
      send(8'h12); idle(1);
      send_lo(8'h34, '0, 16'h1234); idle(1);
      send(8'h27); idle(1);
      settle();
      check_end("csum_bad", 1, 0, 1, 1'b1, we0, ld0);
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_len_err();
      test_ignore();
      test_back_to_back();
      test_full();
      test_reset_mid();
`ifdef MEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
